// File: rtl/raycast_pkg.sv
// Shared raycaster types: screen geometry, frame-scheduler states and the player pose record.
package raycast_pkg;

    localparam int RAY_SCREEN_WIDTH  = 320;
    localparam int RAY_SCREEN_HEIGHT = 240;
    localparam int RAY_POSE_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        ISSUE,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        logic [RAY_POSE_W-1:0] pos_x;
        logic [RAY_POSE_W-1:0] pos_y;
        logic [RAY_POSE_W-1:0] dir_x;
        logic [RAY_POSE_W-1:0] dir_y;
        logic [RAY_POSE_W-1:0] plane_x;
        logic [RAY_POSE_W-1:0] plane_y;
    } pose_t;

endpackage

// File: rtl/drain_watchdog.sv
// Loadable up-counter that stops and flags once it reaches LIMIT; used to bound pipeline-drain waits.
module drain_watchdog #(
    parameter int             W     = 16,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    assign expired = (count == LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Per-frame column sequencer for the raycaster: latches the pose, issues columns, waits for drain.
// Optional statistics counters are enabled by defining RAY_SCHED_STATS_EN.
module ray_frame_scheduler #(
    parameter int SCREEN_WIDTH  = raycast_pkg::RAY_SCREEN_WIDTH,
    parameter int HCOUNT_W      = 9,
    parameter int POSE_W        = raycast_pkg::RAY_POSE_W,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                new_frame_in,
    input  logic [POSE_W-1:0]   posX_in,
    input  logic [POSE_W-1:0]   posY_in,
    input  logic [POSE_W-1:0]   dirX_in,
    input  logic [POSE_W-1:0]   dirY_in,
    input  logic [POSE_W-1:0]   planeX_in,
    input  logic [POSE_W-1:0]   planeY_in,
    input  logic                ray_tready_in,
    output logic                ray_tvalid_out,
    output logic                ray_tlast_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [POSE_W-1:0]   posX_out,
    output logic [POSE_W-1:0]   posY_out,
    output logic [POSE_W-1:0]   dirX_out,
    output logic [POSE_W-1:0]   dirY_out,
    output logic [POSE_W-1:0]   planeX_out,
    output logic [POSE_W-1:0]   planeY_out,
    input  logic                frame_done_in,
    output logic                busy_out,
    output logic                timeout_err_out
`ifdef RAY_SCHED_STATS_EN
    ,
    output logic [15:0]         frames_skipped_out,
    output logic [15:0]         frames_done_out
`endif
);

    import raycast_pkg::*;

    localparam int                  CNT_W       = (DRAIN_TIMEOUT < 2) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_VAL = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [HCOUNT_W-1:0] LAST_COL    = HCOUNT_W'(SCREEN_WIDTH - 1);

    sched_state_t state, state_next;

    logic handshake;
    logic last_col;
    logic drain_expired;
    logic frame_done_exit;
    logic new_frame_ignored;

    assign ray_tvalid_out    = (state == ISSUE);
    assign last_col          = (hcount_out == LAST_COL);
    assign ray_tlast_out     = ray_tvalid_out && last_col;
    assign handshake         = ray_tvalid_out && ray_tready_in;
    assign busy_out          = (state != IDLE);
    assign frame_done_exit   = (state == DRAIN) && frame_done_in;
    // A pulse that lands on the drain-completion cycle starts the next frame instead of being dropped.
    assign new_frame_ignored = new_frame_in && (state != IDLE) && !frame_done_exit;

    drain_watchdog #(
        .W     (CNT_W),
        .LIMIT (TIMEOUT_VAL)
    ) u_drain_watchdog (
        .clk        (pixel_clk_in),
        .rst        (rst_in),
        .load       (state != DRAIN),
        .load_value ('0),
        .enable     (state == DRAIN),
        .expired    (drain_expired)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (new_frame_in) state_next = LATCH;
            LATCH: state_next = ISSUE;
            ISSUE: if (handshake && last_col) state_next = DRAIN;
            DRAIN: begin
                if (frame_done_in) begin
                    state_next = new_frame_in ? LATCH : IDLE;
                end else if (drain_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_out      <= '0;
            posX_out        <= '0;
            posY_out        <= '0;
            dirX_out        <= '0;
            dirY_out        <= '0;
            planeX_out      <= '0;
            planeY_out      <= '0;
            timeout_err_out <= 1'b0;
        end else begin
            if (state == LATCH) begin
                hcount_out <= '0;
                posX_out   <= posX_in;
                posY_out   <= posY_in;
                dirX_out   <= dirX_in;
                dirY_out   <= dirY_in;
                planeX_out <= planeX_in;
                planeY_out <= planeY_in;
            end else if (handshake && !last_col) begin
                hcount_out <= hcount_out + 1'b1;
            end
            if ((state == DRAIN) && !frame_done_in && drain_expired) begin
                timeout_err_out <= 1'b1;
            end
        end
    end

`ifdef RAY_SCHED_STATS_EN
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            frames_skipped_out <= '0;
            frames_done_out    <= '0;
        end else begin
            if (new_frame_ignored && (frames_skipped_out != 16'hFFFF)) begin
                frames_skipped_out <= frames_skipped_out + 1'b1;
            end
            if (frame_done_exit) begin
                frames_done_out <= frames_done_out + 1'b1;
            end
        end
    end
`else
    logic unused_ignored;
    assign unused_ignored = new_frame_ignored;
`endif

endmodule

// File: doc/ray_frame_scheduler.md
Name: ray_frame_scheduler

Overview:
Sequences the raycasting datapath once per video frame. On each new-frame pulse it snapshots the controller's player pose, then issues column indices 0..SCREEN_WIDTH-1 to ray_calculations over a valid/ready handshake, holding the pose constant for the whole frame. It then waits for the transformation stage's last-pixel pulse before accepting another frame. It replaces the free-running column counter between controller and ray_calculations.

Parameters:
SCREEN_WIDTH, 320, number of columns issued per frame
HCOUNT_W, 9, width of column index
POSE_W, 16, width of each pose component
DRAIN_TIMEOUT, 65535, max DRAIN cycles before forced abort

Ports:
pixel_clk_in  in  1  pixel clock
rst_in  in  1  synchronous active-high reset
new_frame_in  in  1  one-cycle new-frame pulse from video_sig_gen
posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  in  POSE_W each  live pose from controller
ray_tready_in  in  1  ray_calculations ready
ray_tvalid_out  out  1  column request valid
ray_tlast_out  out  1  high with last column of frame
hcount_out  out  HCOUNT_W  column index
posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out  out  POSE_W each  frame-latched pose
frame_done_in  in  1  ray_last_pixel_out pulse from transformation
busy_out  out  1  high in any state except IDLE
timeout_err_out  out  1  sticky: DRAIN timed out

Behaviour:
- Reset: state IDLE; all outputs 0; pose registers 0; counters 0. Reset mid-frame aborts immediately, with no partial handshake held.
- IDLE: new_frame_in=1 -> LATCH.
- LATCH (1 cycle): register all six pose inputs into *_out; hcount_out<=0 -> ISSUE. ray_tvalid_out rises 2 cycles after the new_frame_in edge.
- ISSUE: ray_tvalid_out=1.
  - hcount_out and pose stay stable while tvalid && !tready.
  - On tvalid && tready: if hcount_out==SCREEN_WIDTH-1 -> DRAIN with tvalid dropping next cycle; else hcount_out+1.
  - ray_tlast_out = tvalid && hcount_out==SCREEN_WIDTH-1.
  - Exactly SCREEN_WIDTH transfers per frame; hcount never wraps within a frame.
- DRAIN: tvalid=0; a drain counter counts up from 0.
  - frame_done_in=1 -> IDLE. If new_frame_in is also 1 that cycle -> LATCH directly, so the frame is not lost.
  - Counter reaches DRAIN_TIMEOUT -> set timeout_err_out (cleared only by reset) -> IDLE.
- new_frame_in in LATCH/ISSUE/DRAIN without the DRAIN completion case above: ignored, and the frame is skipped.
- frame_done_in outside DRAIN: ignored, because it is stale.
- Pose inputs changing during ISSUE/DRAIN have no effect on *_out.
- No arithmetic on the pose; this block only latches it.

Optional Feature:
RAY_SCHED_STATS_EN
- Defined: adds output frames_skipped_out [15:0], which saturates at 0xFFFF and increments on every ignored new_frame_in. Also adds frames_done_out [15:0], which wraps and increments on each DRAIN->IDLE/LATCH exit via frame_done_in. Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- raycast_pkg: SCREEN_WIDTH/SCREEN_HEIGHT constants, the sched_state_t enum {IDLE, LATCH, ISSUE, DRAIN}, and a pose_t packed struct of six POSE_W fields, shared with controller and ray_calculations.
- One natural sub-module: drain_watchdog, a loadable up-counter with a timeout flag, reusable for other FIFO-drain waits.

Test Plan:
1. Reset, then new_frame_in pulse at cycle 10 with ray_tready_in=1 -> tvalid rises cycle 12; hcount 0..319 on consecutive cycles; tlast only at 319; busy_out high through DRAIN.
2. posX_in=0x0100 at the pulse, changed to 0x0200 mid-ISSUE -> posX_out stays 0x0100 for all 320 transfers.
3. ray_tready_in random at 30% -> exactly 320 transfers; hcount/pose stable while stalled; no duplicated or skipped index.
4. In DRAIN, frame_done_in and new_frame_in on the same cycle -> LATCH next cycle, and the new frame issues hcount 0.
5. DRAIN_TIMEOUT=100 with no frame_done_in -> timeout_err_out=1 at DRAIN cycle 100; IDLE; the next new_frame_in still starts a frame.
6. With RAY_SCHED_STATS_EN, 3 new_frame_in pulses during ISSUE -> frames_skipped_out=3; rst_in asserted mid-ISSUE -> all outputs 0 next cycle.
